mem_dma_engine: RTL and testbench

//  Bus initiator for the 64KB data SRAM port (we/addr/wdata/wstrb, combinational rdata).

---
 rtl/mem_dma_engine_pkg.sv | 35 +++
 rtl/mem_dma_engine_if.sv | 16 +
 rtl/mem_dma_engine_range_check.sv | 36 +++
 rtl/mem_dma_engine.sv | 169 ++++++++++++++++
 tb/tb_mem_dma_engine.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dma_engine_pkg.sv
// Shared widths, state encodings, op/error codes and command payload for the
// SRAM fill/copy DMA engine.
package mem_dma_engine_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 15;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SUM_W  = LEN_W + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_VRF   = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  typedef enum logic {OP_FILL = 1'b0, OP_COPY = 1'b1} dma_op_e;

  typedef enum logic [2:0] {
    ERR_OK      = 3'd0,
    ERR_RANGE   = 3'd1,
    ERR_OVERLAP = 3'd2,
    ERR_ABORT   = 3'd3,
    ERR_VERIFY  = 3'd4
  } dma_err_e;

  typedef struct packed {
    dma_op_e             op;
    logic [ADDR_W-1:0]   src;
    logic [ADDR_W-1:0]   dst;
    logic [LEN_W-1:0]    len;
  } dma_cmd_t;

endpackage

// File: rtl/mem_dma_engine_if.sv
// Data-SRAM port as seen through the arbiter: request/grant plus a word-wide
// write bus and combinational read data.
interface mem_dma_engine_if;
  import mem_dma_engine_pkg::*;

  logic              req;
  logic              gnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input gnt, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output gnt, rdata);
endinterface

// File: rtl/mem_dma_engine_range_check.sv
// Combinational screening of a latched command: empty transfer, address-space
// overrun, and forward-overlapping copy all finish without touching memory.
module mem_dma_engine_range_check
  import mem_dma_engine_pkg::*;
(
  input  dma_cmd_t i_cmd,
  output logic     o_skip_c,
  output dma_err_e o_err_c
);

  localparam logic [SUM_W-1:0] LIMIT = SUM_W'(2 ** ADDR_W);

  logic [SUM_W-1:0] w_src_end;
  logic [SUM_W-1:0] w_dst_end;
  logic             w_is_copy;

  assign w_src_end = SUM_W'(i_cmd.src) + SUM_W'(i_cmd.len);
  assign w_dst_end = SUM_W'(i_cmd.dst) + SUM_W'(i_cmd.len);
  assign w_is_copy = (i_cmd.op == OP_COPY);

  // Ascending copy is only unsafe when dst lands inside the not-yet-read source.
  always_comb begin
    o_skip_c = 1'b1;
    o_err_c  = ERR_OK;
    if (i_cmd.len == '0) begin
      o_err_c = ERR_OK;
    end else if ((w_dst_end > LIMIT) || (w_is_copy && (w_src_end > LIMIT))) begin
      o_err_c = ERR_RANGE;
    end else if (w_is_copy && (i_cmd.src < i_cmd.dst) && (SUM_W'(i_cmd.dst) < w_src_end)) begin
      o_err_c = ERR_OVERLAP;
    end else begin
      o_skip_c = 1'b0;
    end
  end

endmodule

// File: rtl/mem_dma_engine.sv
// Word-granular FILL/COPY initiator on the data-SRAM port; moves words only on grant.
// Optional DMA_READBACK_EN adds a verify read after every committed write.
module mem_dma_engine
  import mem_dma_engine_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_op,
  input  logic [ADDR_W-1:0]  i_src_addr,
  input  logic [ADDR_W-1:0]  i_dst_addr,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [DATA_W-1:0]  i_fill_data,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_done,
  output logic [2:0]         o_err_code,
  output logic [LEN_W-1:0]   o_words_done,
  mem_dma_engine_if.master   m_mem
);

  logic [2:0]        r_state, w_state_nxt;
  dma_cmd_t          r_cmd, w_cmd_nxt;
  logic [ADDR_W-1:0] r_src, w_src_nxt;
  logic [ADDR_W-1:0] r_dst, w_dst_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [LEN_W-1:0]  r_words, w_words_nxt;
  dma_err_e          r_err, w_err_nxt;
  logic              r_busy, r_done, r_req, r_we;
  logic [ADDR_W-1:0] r_addr;

  logic              w_fire;
  logic              w_skip;
  dma_err_e          w_chk_err;
  logic [LEN_W-1:0]  w_words_inc;

  mem_dma_engine_range_check u_range_check (
    .i_cmd    (r_cmd),
    .o_skip_c (w_skip),
    .o_err_c  (w_chk_err)
  );

  assign w_fire      = r_req & m_mem.gnt;
  assign w_words_inc = r_words + LEN_W'(1);

  // Next-state, counters and hold register; r_wdata is both FILL pattern and COPY hold.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_wdata_nxt = r_wdata;
    w_words_nxt = r_words;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_CHECK;
          w_cmd_nxt   = '{op: dma_op_e'(i_op), src: i_src_addr, dst: i_dst_addr, len: i_len};
          w_src_nxt   = i_src_addr;
          w_dst_nxt   = i_dst_addr;
          w_wdata_nxt = i_fill_data;
          w_words_nxt = '0;
          w_err_nxt   = ERR_OK;
        end
      end
      ST_CHECK: begin
        if (w_skip) begin
          w_state_nxt = ST_FIN;
          w_err_nxt   = w_chk_err;
        end else begin
          w_state_nxt = (r_cmd.op == OP_COPY) ? ST_RD : ST_WR;
        end
      end
      ST_RD: begin
        if (w_fire) w_wdata_nxt = m_mem.rdata;
        if (i_abort) begin
          w_state_nxt = ST_FIN;
          w_err_nxt   = ERR_ABORT;
        end else if (w_fire) begin
          w_state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        if (w_fire) w_words_nxt = w_words_inc;
        if (i_abort) begin
          w_state_nxt = ST_FIN;
          w_err_nxt   = ERR_ABORT;
        end else if (w_fire) begin
`ifdef DMA_READBACK_EN
          w_state_nxt = ST_VRF;
`else
          if (w_words_inc == r_cmd.len) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_src_nxt   = r_src + ADDR_W'(1);
            w_dst_nxt   = r_dst + ADDR_W'(1);
            w_state_nxt = (r_cmd.op == OP_COPY) ? ST_RD : ST_WR;
          end
`endif
        end
      end
`ifdef DMA_READBACK_EN
      // Re-read the word just written; a bad word is already counted in words_done.
      ST_VRF: begin
        if (w_fire && (m_mem.rdata != r_wdata)) begin
          w_state_nxt = ST_FIN;
          w_err_nxt   = ERR_VERIFY;
        end else if (i_abort) begin
          w_state_nxt = ST_FIN;
          w_err_nxt   = ERR_ABORT;
        end else if (w_fire) begin
          if (r_words == r_cmd.len) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_src_nxt   = r_src + ADDR_W'(1);
            w_dst_nxt   = r_dst + ADDR_W'(1);
            w_state_nxt = (r_cmd.op == OP_COPY) ? ST_RD : ST_WR;
          end
        end
      end
`endif
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Port-facing outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cmd   <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_wdata <= '0;
      r_words <= '0;
      r_err   <= ERR_OK;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_wdata <= w_wdata_nxt;
      r_words <= w_words_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt inside {ST_CHECK, ST_RD, ST_WR, ST_VRF});
      r_done  <= (w_state_nxt == ST_FIN);
      r_req   <= (w_state_nxt inside {ST_RD, ST_WR, ST_VRF});
      r_we    <= (w_state_nxt == ST_WR);
      r_addr  <= (w_state_nxt == ST_RD) ? w_src_nxt : w_dst_nxt;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err_code   = r_err;
  assign o_words_done = r_words;
  assign m_mem.req    = r_req;
  assign m_mem.we     = r_we;
  assign m_mem.addr   = r_addr;
  assign m_mem.wdata  = r_wdata;
  assign m_mem.wstrb  = {STRB_W{r_we}};

endmodule

// File: tb/tb_mem_dma_engine.sv
// Scoreboard bench for mem_dma_engine: directed ops push expected writes and
// completions; a negedge monitor pops and compares what the DUT presents.
module tb_mem_dma_engine;
  import mem_dma_engine_pkg::*;

`ifdef DMA_READBACK_EN
  localparam int CPW_FILL = 2;
`else
  localparam int CPW_FILL = 1;
`endif

  typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} wr_t;
  typedef struct packed {logic [2:0] err; logic [LEN_W-1:0] words;} res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, start, op, abort;
  logic [ADDR_W-1:0]  src, dst;
  logic [LEN_W-1:0]   len;
  logic [DATA_W-1:0]  fill;
  logic               busy, done;
  logic [2:0]         err;
  logic [LEN_W-1:0]   words;

  mem_dma_engine_if mem_if();

  mem_dma_engine dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_op(op),
    .i_src_addr(src), .i_dst_addr(dst), .i_len(len), .i_fill_data(fill),
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_err_code(err),
    .o_words_done(words), .m_mem(mem_if)
  );

  wr_t  wr_q[$];
  res_t res_q[$];
  bit   gnt_q[$];
  int   n_vec = 0, n_bad = 0;
  int   done_cnt = 0, req_cycles = 0, wr_count = 0, exp_done = 0;
  time  t_done = 0;

  logic [DATA_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
  logic              pre_we, corrupt_en;
  logic [ADDR_W-1:0] pre_addr, corrupt_addr;
  logic [DATA_W-1:0] pre_data;

  assign mem_if.rdata = mem_arr[mem_if.addr];

  // SRAM model; corrupt_en flips bit 0 of one address to provoke a verify failure.
  always @(posedge clk) begin
    if (pre_we) begin
      mem_arr[pre_addr] <= pre_data;
    end else if (mem_if.req && mem_if.gnt && mem_if.we) begin
      mem_arr[mem_if.addr] <= (corrupt_en && mem_if.addr == corrupt_addr) ?
                              (mem_if.wdata ^ 32'h1) : mem_if.wdata;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    mem_if.gnt = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (mem_if.req && gnt_q.size() > 0) mem_if.gnt = gnt_q.pop_front();
      else mem_if.gnt = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic              stall_chk = 1'b0, prev_stall = 1'b0, prev_we = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin : monitor
    wr_t  ew;
    res_t er;
    if (rst_n) begin
      if (mem_if.req) req_cycles++;
      if (stall_chk && prev_stall) begin
        check("stall_addr", 64'(mem_if.addr), 64'(prev_addr));
        check("stall_we", 64'(mem_if.we), 64'(prev_we));
      end
      prev_stall = mem_if.req && !mem_if.gnt;
      prev_addr  = mem_if.addr;
      prev_we    = mem_if.we;
      if (mem_if.req && mem_if.gnt && mem_if.we) begin
        if (wr_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", mem_if.addr, mem_if.wdata);
        end else begin
          ew = wr_q.pop_front();
          check("wr_addr", 64'(mem_if.addr), 64'(ew.addr));
          check("wr_data", 64'(mem_if.wdata), 64'(ew.data));
          check("wr_strb", 64'(mem_if.wstrb), 64'hF);
        end
      end
      if (done) begin
        done_cnt++;
        t_done = $time;
        if (res_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_done: err %0d words %0d", err, words);
        end else begin
          er = res_q.pop_front();
          check("done_err", 64'(err), 64'(er.err));
          check("done_words", 64'(words), 64'(er.words));
          check("done_busy", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_res(input logic [2:0] e, input logic [LEN_W-1:0] n);
    res_t r;
    r.err = e; r.words = n;
    res_q.push_back(r);
  endtask

  task automatic start_op(input logic o, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] f, output time t0);
    op = o; src = s; dst = d; len = l; fill = f; start = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    exp_done++;
    while (done_cnt < exp_done && n < 300) begin
      @(posedge clk);
      n++;
    end
    n_vec++;
    if (done_cnt < exp_done) begin
      n_bad++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, exp_done);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    int  base, cyc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 1'b0;
    src = '0; dst = '0; len = '0; fill = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; corrupt_en = 1'b0; corrupt_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req", 64'(mem_if.req), 64'd0);
    check("rst_we", 64'(mem_if.we), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_words", 64'(words), 64'd0);
    check("rst_addr", 64'(mem_if.addr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zeroize four words; start edge through done spans 2 + len*CPW_FILL cycles.
    for (int i = 0; i < 4; i++) preload(ADDR_W'(14'h100 + i), 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) push_wr(ADDR_W'(14'h100 + i), 32'h0);
    push_res(3'd0, 15'd4);
    start_op(1'b0, 14'h0, 14'h100, 15'd4, 32'h0, t0);
    wait_done();
    cyc = int'((t_done - t0 - 5) / 10) + 1;
    check("fill_cycles", 64'(cyc), 64'(2 + 4 * CPW_FILL));
    for (int i = 0; i < 4; i++) check("fill_mem", 64'(mem_arr[14'h100 + i]), 64'h0);

    // COPY three words forward, no overlap.
    preload(14'h10, 32'hA000_0001);
    preload(14'h11, 32'hB000_0002);
    preload(14'h12, 32'hC000_0003);
    push_wr(14'h20, 32'hA000_0001);
    push_wr(14'h21, 32'hB000_0002);
    push_wr(14'h22, 32'hC000_0003);
    push_res(3'd0, 15'd3);
    start_op(1'b1, 14'h10, 14'h20, 15'd3, 32'h0, t0);
    wait_done();
    check("copy_mem0", 64'(mem_arr[14'h20]), 64'hA000_0001);
    check("copy_mem1", 64'(mem_arr[14'h21]), 64'hB000_0002);
    check("copy_mem2", 64'(mem_arr[14'h22]), 64'hC000_0003);
    check("copy_words_held", 64'(words), 64'd3);

    // Grant stalls mid-FILL: address and we must hold.
    gnt_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    stall_chk = 1'b1;
    base = wr_count;
    push_wr(14'h200, 32'h5A5A_1234);
    push_wr(14'h201, 32'h5A5A_1234);
    push_res(3'd0, 15'd2);
    start_op(1'b0, 14'h0, 14'h200, 15'd2, 32'h5A5A_1234, t0);
    wait_done();
    stall_chk = 1'b0;
    check("stall_wr_count", 64'(wr_count - base), 64'd2);
    check("stall_mem0", 64'(mem_arr[14'h200]), 64'h5A5A_1234);
    check("stall_mem1", 64'(mem_arr[14'h201]), 64'h5A5A_1234);

    // Zero length: completes without ever requesting the port.
    base = req_cycles;
    push_res(3'd0, 15'd0);
    start_op(1'b0, 14'h0, 14'h500, 15'd0, 32'h1, t0);
    wait_done();
    check("len0_req_cycles", 64'(req_cycles - base), 64'd0);

    // Range boundary: exactly reaching the top is fine, one past is rejected.
    for (int i = 0; i < 4; i++) push_wr(ADDR_W'(14'h3FFC + i), 32'h1234_5678);
    push_res(3'd0, 15'd4);
    start_op(1'b0, 14'h0, 14'h3FFC, 15'd4, 32'h1234_5678, t0);
    wait_done();
    push_res(3'd1, 15'd0);
    start_op(1'b0, 14'h0, 14'h3FFE, 15'd4, 32'h0, t0);
    wait_done();

    // Forward-overlapping COPY rejected.
    push_res(3'd2, 15'd0);
    start_op(1'b1, 14'h10, 14'h12, 15'd4, 32'h0, t0);
    wait_done();

    // Abort coincident with the second fired write of an 8-word FILL.
    preload(14'h302, 32'hDEAD_BEEF);
    push_wr(14'h300, 32'h0F0F_0F0F);
    push_wr(14'h301, 32'h0F0F_0F0F);
    push_res(3'd3, 15'd2);
    base = wr_count;
    start_op(1'b0, 14'h0, 14'h300, 15'd8, 32'h0F0F_0F0F, t0);
    for (int n = 0; n < 50; n++) begin
      if (mem_if.req && mem_if.we && wr_count == base + 1) break;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done();
    check("abort_untouched", 64'(mem_arr[14'h302]), 64'hDEAD_BEEF);

`ifdef DMA_READBACK_EN
    // Memory corrupts the second word; the verify read flags it.
    corrupt_en = 1'b1;
    corrupt_addr = 14'h401;
    push_wr(14'h400, 32'h1111_0000);
    push_wr(14'h401, 32'h1111_0000);
    push_res(3'd4, 15'd2);
    start_op(1'b0, 14'h0, 14'h400, 15'd4, 32'h1111_0000, t0);
    wait_done();
    corrupt_en = 1'b0;
`endif

    // Reset while a COPY is in its first read: no writes, no done, reset outputs.
    base = done_cnt;
    start_op(1'b1, 14'h10, 14'h40, 15'd3, 32'h0, t0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_req", 64'(mem_if.req), 64'd0);
    check("midrst_words", 64'(words), 64'd0);
    check("midrst_addr", 64'(mem_if.addr), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - base), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);

    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("res_q_empty", 64'(res_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
